// File: rtl/tcam_params.sv
// Shared TCAM widths and segment status encodings used by the priority merge block.
package tcam_params;

    localparam int unsigned KWID   = 104;
    localparam int unsigned SEGWID = 10;
    localparam int unsigned NSEG   = KWID / 8;
    localparam int unsigned IDWID  = 8;
    localparam int unsigned PRIOR  = 8;
    localparam int unsigned CFWID  = 1 + IDWID + PRIOR;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StMatch = 2'b01,
        StMiss  = 2'b10,
        StErr   = 2'b11
    } seg_status_e;

endpackage

// File: rtl/prio_merge_if.sv
// Search/result and priority-table write signals of prio_merge, grouped with driver/DUT views.
interface prio_merge_if #(
    parameter int unsigned NSEG   = tcam_params::NSEG,
    parameter int unsigned SEGWID = tcam_params::SEGWID,
    parameter int unsigned IDWID  = tcam_params::IDWID,
    parameter int unsigned PRIOR  = tcam_params::PRIOR,
    parameter int unsigned CFWID  = tcam_params::CFWID
);

    logic                     i_Valid;
    logic [NSEG*SEGWID-1:0]   i_Compare_Results;
    logic                     i_Pri_We;
    logic [IDWID-1:0]         i_Pri_Addr;
    logic [PRIOR-1:0]         i_Pri_Data;
    logic                     o_Valid;
    logic [CFWID-1:0]         o_Final;
    logic [3:0]               o_Hit_Count;
    logic                     o_Err;

    modport master (
        output i_Valid, i_Compare_Results, i_Pri_We, i_Pri_Addr, i_Pri_Data,
        input  o_Valid, o_Final, o_Hit_Count, o_Err
    );

    modport slave (
        input  i_Valid, i_Compare_Results, i_Pri_We, i_Pri_Addr, i_Pri_Data,
        output o_Valid, o_Final, o_Hit_Count, o_Err
    );

endinterface

// File: rtl/prio_cmp2.sv
// Combinational 2-way select on packed {valid, rule id, priority}: highest priority, then lowest id.
module prio_cmp2 #(
    parameter int unsigned IDWID = tcam_params::IDWID,
    parameter int unsigned PRIOR = tcam_params::PRIOR
) (
    input  logic [IDWID+PRIOR:0] a,
    input  logic [IDWID+PRIOR:0] b,
    output logic [IDWID+PRIOR:0] y
);

    logic             a_v, b_v;
    logic [IDWID-1:0] a_id, b_id;
    logic [PRIOR-1:0] a_pri, b_pri;
    logic             take_a;

    assign {a_v, a_id, a_pri} = a;
    assign {b_v, b_id, b_pri} = b;

    // Callers feed the lower segment indices on a, so a full tie keeps the lower segment.
    assign take_a = a_v & (~b_v | (a_pri > b_pri) | ((a_pri == b_pri) & (a_id <= b_id)));
    assign y      = take_a ? a : b;

endmodule

// File: rtl/prio_merge.sv
// Three-stage merge of per-segment TCAM compare results into one prioritised winner.
module prio_merge #(
    parameter int unsigned KWID   = tcam_params::KWID,
    parameter int unsigned SEGWID = tcam_params::SEGWID,
    parameter int unsigned NSEG   = KWID / 8,
    parameter int unsigned IDWID  = tcam_params::IDWID,
    parameter int unsigned PRIOR  = tcam_params::PRIOR,
    parameter int unsigned CFWID  = 1 + IDWID + PRIOR
) (
    input logic         clk,
    input logic         rst,
    prio_merge_if.slave bus
);

    import tcam_params::*;

    localparam int unsigned CW   = CFWID;
    localparam int unsigned NGRP = 4;
    localparam int unsigned GSZ  = (NSEG + NGRP - 1) / NGRP;

    logic [PRIOR-1:0] pri_tab_q [2**IDWID];

    logic [NSEG-1:0] is_match, is_err;
    logic [CW-1:0]   cand_d [NSEG];
    logic [CW-1:0]   cand_q [NSEG];
    logic            err_d, v1_q, err1_q;

    logic [CW-1:0]   grp_d [NGRP];
    logic [CW-1:0]   grp_q [NGRP];
    logic [3:0]      hit_d, hit2_q;
    logic            v2_q, err2_q;

    logic [CW-1:0]   half_l, half_r, fin_d;
    logic [CW-1:0]   fin_q;
    logic [3:0]      hit3_q;
    logic            v3_q, err3_q;

    // Stage 1 decode: only a match status becomes a candidate, carrying its table priority.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [1:0]       st;
        logic [IDWID-1:0] id;
        assign st = bus.i_Compare_Results[SEGWID*k+SEGWID-1 -: 2];
        assign id = bus.i_Compare_Results[SEGWID*k +: IDWID];
        assign is_match[k] = bus.i_Valid && (st == StMatch);
        assign is_err[k]   = bus.i_Valid && (st == StErr);
        assign cand_d[k]   = is_match[k] ? {1'b1, id, pri_tab_q[id]} : '0;
    end

    assign err_d = |is_err;

    // Stage 2: each group reduced by an in-order chain so lower segments stay on the a side.
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        logic [CW-1:0] chain [GSZ];
        if (g * GSZ < NSEG) begin : g_head
            assign chain[0] = cand_q[g*GSZ];
        end else begin : g_head_nil
            assign chain[0] = '0;
        end
        for (genvar j = 1; j < GSZ; j++) begin : g_link
            if (g * GSZ + j < NSEG) begin : g_cmp
                prio_cmp2 #(.IDWID(IDWID), .PRIOR(PRIOR)) u_cmp (
                    .a(chain[j-1]),
                    .b(cand_q[g*GSZ+j]),
                    .y(chain[j])
                );
            end else begin : g_pass
                assign chain[j] = chain[j-1];
            end
        end
        assign grp_d[g] = chain[GSZ-1];
    end

    always_comb begin
        hit_d = '0;
        for (int k = 0; k < NSEG; k++) begin
            hit_d = hit_d + {3'b000, cand_q[k][CW-1]};
        end
    end

    // Stage 3: final 4-to-1 tree.
    prio_cmp2 #(.IDWID(IDWID), .PRIOR(PRIOR)) u_cmp_l (.a(grp_q[0]), .b(grp_q[1]), .y(half_l));
    prio_cmp2 #(.IDWID(IDWID), .PRIOR(PRIOR)) u_cmp_r (.a(grp_q[2]), .b(grp_q[3]), .y(half_r));
    prio_cmp2 #(.IDWID(IDWID), .PRIOR(PRIOR)) u_cmp_f (.a(half_l), .b(half_r), .y(fin_d));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**IDWID; i++) begin
                pri_tab_q[i] <= '0;
            end
        end else if (bus.i_Pri_We) begin
            pri_tab_q[bus.i_Pri_Addr] <= bus.i_Pri_Data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q   <= 1'b0;
            err1_q <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                cand_q[k] <= '0;
            end
            v2_q   <= 1'b0;
            err2_q <= 1'b0;
            hit2_q <= '0;
            for (int g = 0; g < NGRP; g++) begin
                grp_q[g] <= '0;
            end
            v3_q   <= 1'b0;
            fin_q  <= '0;
            hit3_q <= '0;
            err3_q <= 1'b0;
        end else begin
            v1_q   <= bus.i_Valid;
            err1_q <= err_d;
            for (int k = 0; k < NSEG; k++) begin
                cand_q[k] <= cand_d[k];
            end
            v2_q   <= v1_q;
            err2_q <= err1_q;
            hit2_q <= hit_d;
            for (int g = 0; g < NGRP; g++) begin
                grp_q[g] <= grp_d[g];
            end
            v3_q   <= v2_q;
            fin_q  <= v2_q ? fin_d : '0;
            hit3_q <= v2_q ? hit2_q : '0;
            err3_q <= v2_q & err2_q;
        end
    end

    assign bus.o_Valid     = v3_q;
    assign bus.o_Final     = fin_q;
    assign bus.o_Hit_Count = hit3_q;
    assign bus.o_Err       = err3_q;

endmodule

// File: tb/tb_prio_merge.sv
// Self-checking bench for prio_merge: directed steps feed a scoreboard checked at every negedge.
module tb_prio_merge;

    localparam int SW  = 10;
    localparam int NS  = 13;
    localparam int CRW = NS * SW;

    typedef struct {
        logic [16:0] fin;
        logic [3:0]  hit;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_on = 1'b0;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    logic [7:0] ref_tab [256];
    exp_t       q [$];
    exp_t       e;

    prio_merge_if bus ();

    prio_merge u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    function automatic exp_t model(input logic [CRW-1:0] cr);
        exp_t       r;
        logic       bv = 1'b0;
        logic [7:0] bid = '0, bp = '0, id, p;
        logic [1:0] st;
        r.hit = '0;
        r.err = 1'b0;
        for (int k = 0; k < NS; k++) begin
            st = cr[k*SW+8 +: 2];
            id = cr[k*SW +: 8];
            if (st == 2'b11) r.err = 1'b1;
            if (st == 2'b01) begin
                r.hit = r.hit + 4'd1;
                p = ref_tab[id];
                if (!bv || p > bp || (p == bp && id < bid)) begin
                    bv = 1'b1;
                    bid = id;
                    bp = p;
                end
            end
        end
        r.fin = bv ? {1'b1, bid, bp} : 17'h0;
        r.due = cyc + 3;
        return r;
    endfunction

    task automatic step(input logic v, input logic [CRW-1:0] cr, input logic we,
                        input logic [7:0] a, input logic [7:0] d);
        bus.i_Valid = v;
        bus.i_Compare_Results = cr;
        bus.i_Pri_We = we;
        bus.i_Pri_Addr = a;
        bus.i_Pri_Data = d;
        if (v) q.push_back(model(cr));
        if (we) ref_tab[a] = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CRW-1:0] all_st(input logic [1:0] st);
        logic [CRW-1:0] cr;
        for (int k = 0; k < NS; k++) cr[k*SW +: SW] = {st, 8'h00};
        return cr;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("missing_o_valid", 32'd0, 32'd1);
                void'(q.pop_front());
            end
            if (bus.o_Valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_o_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("final", {15'h0, bus.o_Final}, {15'h0, e.fin});
                    chk("hit_count", {28'h0, bus.o_Hit_Count}, {28'h0, e.hit});
                    chk("err", {31'h0, bus.o_Err}, {31'h0, e.err});
                end
            end else begin
                chk("idle_outputs_zero", {10'h0, bus.o_Final, bus.o_Hit_Count, bus.o_Err}, 32'h0);
            end
        end
    end

    initial begin
        logic [CRW-1:0] cr;
        for (int i = 0; i < 256; i++) ref_tab[i] = 8'h00;
        bus.i_Valid = 1'b0;
        bus.i_Compare_Results = '0;
        bus.i_Pri_We = 1'b0;
        bus.i_Pri_Addr = '0;
        bus.i_Pri_Data = '0;
        rst = 1'b0;
        #1 mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Winner by highest priority: expect {1,0x09,0x20}, hit 2.
        step(1'b0, '0, 1'b1, 8'd5, 8'h10);
        step(1'b0, '0, 1'b1, 8'd9, 8'h20);
        cr = all_st(2'b10);
        cr[2*SW +: SW] = {2'b01, 8'd5};
        cr[7*SW +: SW] = {2'b01, 8'd9};
        step(1'b1, cr, 1'b0, '0, '0);

        // Equal priorities: lowest rule id (3) wins.
        step(1'b0, '0, 1'b1, 8'd3, 8'h40);
        step(1'b0, '0, 1'b1, 8'd4, 8'h40);
        cr = all_st(2'b10);
        cr[0*SW +: SW] = {2'b01, 8'd4};
        cr[12*SW +: SW] = {2'b01, 8'd3};
        step(1'b1, cr, 1'b0, '0, '0);

        // Error-only segment: no candidate, o_Err set.
        cr = all_st(2'b00);
        cr[6*SW +: SW] = {2'b11, 8'd5};
        step(1'b1, cr, 1'b0, '0, '0);

        // Same-cycle write is not seen; next search sees 0x80.
        step(1'b0, '0, 1'b1, 8'd7, 8'h01);
        cr = all_st(2'b10);
        cr[4*SW +: SW] = {2'b01, 8'd7};
        step(1'b1, cr, 1'b1, 8'd7, 8'h80);
        step(1'b1, cr, 1'b0, '0, '0);
        repeat (4) step(1'b0, '0, 1'b0, '0, '0);

        // Back-to-back random traffic with small id range and priorities to force ties.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 8'(i), 8'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NS; k++) begin
                cr[k*SW +: SW] = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
            end
            step(1'b1, cr, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)),
                 8'($urandom_range(0, 3)));
        end
        repeat (5) step(1'b0, '0, 1'b0, '0, '0);

        // Reset with two results in flight: nothing may emerge, table clears.
        step(1'b0, '0, 1'b1, 8'd7, 8'h55);
        cr = all_st(2'b10);
        cr[0*SW +: SW] = {2'b01, 8'd7};
        step(1'b1, cr, 1'b0, '0, '0);
        step(1'b1, cr, 1'b0, '0, '0);
        bus.i_Valid = 1'b0;
        #2 rst = 1'b0;
        q.delete();
        for (int i = 0; i < 256; i++) ref_tab[i] = 8'h00;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) step(1'b0, '0, 1'b0, '0, '0);
        step(1'b1, cr, 1'b0, '0, '0);
        repeat (6) step(1'b0, '0, 1'b0, '0, '0);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prio_merge.md
PRIO_MERGE -- requirements
Module: prio_merge

Interface
REQ-001 The parameters SHALL be: KWID, default 104, key width; SEGWID, default 10, segment result width (2 status bits plus IDWID); NSEG, default KWID/8 = 13, number of segments; IDWID, default 8, rule ID width; PRIOR, default 8, priority width; CFWID, default 1+IDWID+PRIOR = 17, final result width.
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset, asynchronous and active-low.
REQ-004 i_Valid  input  1  Compare results present this cycle.
REQ-005 i_Compare_Results  input  NSEG*SEGWID  Packed compare results; segment k occupies [SEGWID*k+SEGWID-1 : SEGWID*k].
REQ-006 i_Pri_We  input  1  Priority-table write strobe.
REQ-007 i_Pri_Addr  input  IDWID  Rule ID to write.
REQ-008 i_Pri_Data  input  PRIOR  Priority value to write.
REQ-009 o_Valid  output  1  Final result valid.
REQ-010 o_Final  output  CFWID  Packed {match, rule ID, priority}.
REQ-011 o_Hit_Count  output  4  Number of segments reporting a match.
REQ-012 o_Err  output  1  At least one segment reported status 2'b11.

Function
REQ-013 Segment format SHALL be [SEGWID-1:SEGWID-2] status (00 empty, 01 match, 10 miss, 11 error) and [IDWID-1:0] rule ID.
REQ-014 Only status 01 SHALL make a segment a candidate; error segments SHALL set o_Err and never be candidates.
REQ-015 The block SHALL hold a 2^IDWID x PRIOR priority table, and each candidate's priority SHALL be table[rule ID].
REQ-016 The winner SHALL be the candidate with the numerically highest priority; ties SHALL be broken by lowest rule ID, then by lowest segment index.
REQ-017 The block SHALL be fully pipelined: it accepts one input per cycle with no backpressure, and latency from i_Valid to o_Valid SHALL be exactly 3 cycles.
REQ-018 Stage 1 SHALL register the inputs and the per-segment priority lookups; stage 2 SHALL reduce 13 candidates to 4; stage 3 SHALL reduce 4 to 1 and register the outputs.
REQ-019 With no candidates, o_Final SHALL be all zeros (match=0, ID=0, priority=0); o_Hit_Count and o_Err SHALL remain valid.
REQ-020 When o_Valid=0, o_Final, o_Hit_Count and o_Err SHALL be 0.
REQ-021 A table write in cycle N SHALL be visible to inputs accepted in cycle N+1 and later; an input accepted in cycle N SHALL see the old value.
REQ-022 Writes SHALL be independent of i_Valid; a write and a search in the same cycle are both legal.
REQ-023 o_Hit_Count SHALL saturate-free count from 0 to 13 (4 bits suffice).

Reset
REQ-024 Asserting rst SHALL asynchronously clear all pipeline valid bits and all outputs to 0.
REQ-025 Reset SHALL clear every priority-table entry to 0.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight results; no o_Valid pulse SHALL appear for inputs accepted before reset.
REQ-027 After rst deasserts, the first input accepted SHALL produce o_Valid exactly 3 cycles later.

Structure
REQ-028 KWID, SEGWID, IDWID, PRIOR, CFWID, NSEG and the status encodings SHALL live in the shared TCAM parameter package/include, tcam_params.
REQ-029 A single sub-module prio_cmp2 SHALL be used: a combinational 2-input compare-select cell implementing REQ-016, instanced to form the reduction tree.
REQ-030 The priority table SHALL be a flop array, because 13 reads per cycle are required.

Verification
REQ-031 Write table[5]=0x10 and table[9]=0x20; segments 2 and 7 match IDs 5 and 9, all others miss -> 3 cycles later, o_Final={1,0x09,0x20} and o_Hit_Count=2.
REQ-032 table[3]=table[4]=0x40; segment 0 matches ID 4 and segment 12 matches ID 3 -> winner ID 3, priority 0x40, o_Hit_Count=2.
REQ-033 All segments empty, with segment 6 status 11 -> o_Final=0, o_Hit_Count=0, o_Err=1.
REQ-034 Back-to-back i_Valid for 20 cycles with random results -> 20 consecutive o_Valid pulses, each matching the reference model in order.
REQ-035 Write table[7]=0x80 in the same cycle as a search hitting ID 7 (old value 0x01) -> that result reports 0x01; a search one cycle later reports 0x80.
REQ-036 Assert rst with 2 results in flight -> no o_Valid appears; table[7] reads 0 on the next search.
